// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer sequencer.
//   BCD_W            width of one BCD digit
//   DONE_CYCLES_DEF  default number of 1 Hz ticks that 'done' is held
//   state_t          sequencer state encoding
//   is_bcd()         true for digit codes 0-9
package timer_pkg;

  localparam int unsigned BCD_W           = 4;
  localparam int unsigned DONE_CYCLES_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Keypad entry register: DIGITS BCD digits, newest digit enters at [3:0],
// older digits move up one nibble and the oldest falls off the MSB end.
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-high reset, clears the register
//   clear  in   synchronous clear
//   shift  in   shift in 'digit'
//   digit  in   BCD digit to insert
//   data   out  register contents, MSB nibble = oldest digit
module key_shift_reg
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      shift,
  input  logic [BCD_W-1:0]          digit,
  output logic [BCD_W*DIGITS-1:0]   data
);

  localparam int unsigned DATA_W = BCD_W * DIGITS;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      data <= '0;
    end else if (shift) begin
      // Shift-and-OR form stays legal for DIGITS == 1.
      data <= (data << BCD_W) | DATA_W'(digit);
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Microwave countdown sequencer: collects keypad digits, loads them into the
// counter cascade, gates the 1 Hz count enable and drives magnetron/done.
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   start/resume pulse
//   stop         in   pause request; clears when paused or entering digits
//   door_closed  in   1 = door closed
//   key_valid    in   key_digit strobe
//   key_digit    in   BCD digit (10-15 ignored)
//   one_hz_tick  in   one-cycle pulse per second
//   timer_zero   in   cascade at 00:00
//   data         out  digits to cascade, [3:0] = seconds ones
//   loadn        out  active-low parallel load
//   clearn       out  active-low cascade clear
//   en           out  count enable (tick gated by RUN, same cycle as tick)
//   mag_on       out  magnetron enable
//   done         out  cooking finished
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DONE_CYCLES = DONE_CYCLES_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      door_closed,
  input  logic                      key_valid,
  input  logic [BCD_W-1:0]          key_digit,
  input  logic                      one_hz_tick,
  input  logic                      timer_zero,
  output logic [BCD_W*DIGITS-1:0]   data,
  output logic                      loadn,
  output logic                      clearn,
  output logic                      en,
  output logic                      mag_on,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(DONE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] done_cnt;
  logic             rst_d;
  logic             key_ok;
  logic             start_ok;
  logic             accept_key;
  logic             go_clear;

  assign key_ok   = key_valid && is_bcd(key_digit);
  assign start_ok = start && door_closed && (data != '0);

  // Entry-register control and the "clear and return to IDLE" decision are
  // shared between the shift register and the FSM so both act on one edge.
  always_comb begin
    accept_key = 1'b0;
    go_clear   = 1'b0;
    unique case (state)
      ST_IDLE:  accept_key = key_ok;
      ST_ENTRY: begin
        go_clear   = stop;
        accept_key = key_ok && !stop && !start_ok;
      end
      ST_PAUSE: go_clear = stop;
      ST_DONE:  go_clear = stop || (one_hz_tick && (done_cnt == CNT_LAST));
      default: ;
    endcase
  end

  // Combinational gate so the cascade counts on the very tick cycle;
  // timer_zero wins over a coincident tick.
  assign en = (state == ST_RUN) && one_hz_tick && !timer_zero && !reset;

  key_shift_reg #(
    .DIGITS (DIGITS)
  ) u_key_shift_reg (
    .clock (clock),
    .reset (reset),
    .clear (go_clear),
    .shift (accept_key),
    .digit (key_digit),
    .data  (data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      done_cnt <= '0;
      rst_d    <= 1'b1;
      loadn    <= 1'b1;
      clearn   <= 1'b0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else begin
      rst_d  <= 1'b0;
      loadn  <= 1'b1;
      // Held low one extra cycle after reset release, and for one cycle
      // on every clear-to-IDLE transition.
      clearn <= !(rst_d || go_clear);
      unique case (state)
        ST_IDLE: begin
          if (accept_key) state <= ST_ENTRY;
        end
        ST_ENTRY: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (start_ok) begin
            state <= ST_LOAD;
            loadn <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!door_closed || stop) begin
            state <= ST_PAUSE;
          end else begin
            state  <= ST_RUN;
            mag_on <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!door_closed || stop) begin
            state  <= ST_PAUSE;
            mag_on <= 1'b0;
          end else if (timer_zero) begin
            state    <= ST_DONE;
            mag_on   <= 1'b0;
            done     <= 1'b1;
            done_cnt <= '0;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (start && door_closed) begin
            state  <= ST_RUN;
            mag_on <= 1'b1;
          end
        end
        ST_DONE: begin
          if (go_clear) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (one_hz_tick) begin
            done_cnt <= done_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
